// File: rtl/alu_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer for an ALU that only shifts by 1, 2 or 8 bits.
// Optional step counter output enabled by defining SHIFTSEQ_STATS_EN.
module alu_shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_a,
    output logic [5:0]  alu_ctrl,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
`ifdef SHIFTSEQ_STATS_EN
    ,
    output logic [31:0] step_count
`endif
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CTRL_W  = 6;
    localparam int unsigned TYPE_W  = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [TYPE_W-1:0] OP_SLL  = 2'd0;
    localparam logic [TYPE_W-1:0] OP_SRL  = 2'd1;
    localparam logic [TYPE_W-1:0] OP_RSVD = 2'd3;

    localparam logic [CTRL_W-1:0] CODE_SLL1 = 6'h0A;
    localparam logic [CTRL_W-1:0] CODE_SRL1 = 6'h0D;
    localparam logic [CTRL_W-1:0] CODE_SRA1 = 6'h10;
    localparam logic [CTRL_W-1:0] CODE_NOP  = 6'h00;

    logic [1:0]         state, next_state;
    logic [DATA_W-1:0]  partial, next_partial;
    logic [SHAMT_W-1:0] remaining, next_remaining;
    logic [TYPE_W-1:0]  shift_type, next_type;
    logic [DATA_W-1:0]  next_result;
    logic               next_busy, next_done;
    logic [CTRL_W-1:0]  next_ctrl;

    // Largest fixed distance that does not overshoot the remaining count
    function automatic logic [SHAMT_W-1:0] step_of(input logic [SHAMT_W-1:0] rem);
        if (rem >= SHAMT_W'(8))
            return SHAMT_W'(8);
        else if (rem >= SHAMT_W'(2))
            return SHAMT_W'(2);
        else
            return SHAMT_W'(1);
    endfunction

    // Codes are laid out as base(type) + {0,1,2} for steps {1,2,8}
    function automatic logic [CTRL_W-1:0] step_code(input logic [TYPE_W-1:0]  typ,
                                                    input logic [SHAMT_W-1:0] rem);
        logic [CTRL_W-1:0] base;
        logic [CTRL_W-1:0] idx;
        case (typ)
            OP_SLL:  base = CODE_SLL1;
            OP_SRL:  base = CODE_SRL1;
            default: base = CODE_SRA1;
        endcase
        if (rem >= SHAMT_W'(8))
            idx = CTRL_W'(2);
        else if (rem >= SHAMT_W'(2))
            idx = CTRL_W'(1);
        else
            idx = CTRL_W'(0);
        return base + idx;
    endfunction

    always_comb begin
        next_state     = state;
        next_partial   = partial;
        next_remaining = remaining;
        next_type      = shift_type;
        next_result    = result;
        next_busy      = 1'b0;
        next_done      = 1'b0;
        next_ctrl      = CODE_NOP;

        case (state)
            S_IDLE: begin
                if (start && (op != OP_RSVD)) begin
                    next_partial   = operand;
                    next_remaining = shamt;
                    next_type      = op;
                    next_state     = (shamt == SHAMT_W'(0)) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                next_partial   = alu_result;
                next_remaining = remaining - step_of(remaining);
                if (next_remaining == SHAMT_W'(0))
                    next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the upcoming state
        next_busy = (next_state != S_IDLE);
        next_done = (next_state == S_DONE);
        if (next_state == S_DONE)
            next_result = next_partial;
        if (next_state == S_SHIFT)
            next_ctrl = step_code(next_type, next_remaining);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            partial    <= '0;
            remaining  <= '0;
            shift_type <= '0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_ctrl   <= CODE_NOP;
        end else begin
            state      <= next_state;
            partial    <= next_partial;
            remaining  <= next_remaining;
            shift_type <= next_type;
            result     <= next_result;
            busy       <= next_busy;
            done       <= next_done;
            alu_ctrl   <= next_ctrl;
        end
    end

    assign alu_a = partial;

`ifdef SHIFTSEQ_STATS_EN
    // Saturating count of SHIFT cycles, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            step_count <= '0;
        else if ((state == S_SHIFT) && (step_count != {DATA_W{1'b1}}))
            step_count <= step_count + DATA_W'(1);
    end
`endif

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller that executes MIPS SLL/SRL/SRA with any shift amount 0–31 on an ALU whose shift operations only support fixed distances of 1, 2 and 8 bits. It sits between the decode/control stage and the ALU and stalls the pipeline while it runs. It breaks the shift amount into a sequence of fixed-distance ALU shift steps and feeds each partial result back as the next ALU operand.

## Interface
- No parameters. Data width is fixed at 32, shift amount at 5 bits, and ALU control at 6 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  shift type: 0 = SLL, 1 = SRL, 2 = SRA, 3 = reserved
- shamt  in  5  shift amount, 0–31
- operand  in  32  value to shift; sampled with start
- alu_result  in  32  combinational result of the ALU for the current alu_a/alu_ctrl
- alu_a  out  32  ALU operand; holds the current partial value
- alu_ctrl  out  6  ALU control code for the current step
- busy  out  1  high in SHIFT and DONE; drives the pipeline stall
- done  out  1  one-cycle pulse; result is valid in that cycle
- result  out  32  final shifted value; held until the next accepted start
- step_count  out  32  only present with SHIFTSEQ_STATS_EN

## Operation
**States.** The block has three states: IDLE, SHIFT and DONE.

**Accepting a request.**
- A request is accepted when the state is IDLE, start = 1 and op ≠ 3.
- op = 3 is ignored: no state change and no done.
- On acceptance, operand is loaded into the partial register, shamt into the remaining register, and op into the type register.
- If shamt = 0, the next state is DONE. Otherwise it is SHIFT.

**SHIFT step selection.** The step is chosen greedily from the remaining count:
- remaining ≥ 8: step 8
- else remaining ≥ 2: step 2
- else: step 1

**Step codes on alu_ctrl:**
- SLL: step 1 = 0x0A, step 2 = 0x0B, step 8 = 0x0C
- SRL: step 1 = 0x0D, step 2 = 0x0E, step 8 = 0x0F
- SRA: step 1 = 0x10, step 2 = 0x11, step 8 = 0x12

**Each SHIFT cycle:**
- alu_a = partial, and alu_ctrl = the code for the selected step.
- At the clock edge: partial <= alu_result and remaining <= remaining − step.
- When the new remaining value is 0, the next state is DONE.

**DONE:**
- result <= partial (captured at entry to DONE) and done = 1.
- The next state is always IDLE.
- start is ignored in DONE.

**Outside SHIFT:** alu_ctrl = 0x00 and alu_a = partial.

**Step count:** the number of steps is floor(shamt/8) + floor((shamt mod 8)/2) + (shamt mod 2). The maximum is 7 steps, at shamt = 31.

**Arithmetic:** all 32-bit. The block performs no shifting itself; bit behaviour (zero fill, sign fill) comes from the ALU.

## Timing
**Reset values.** When rst_n = 0 at an edge:
- State goes to IDLE.
- partial, remaining, result = 0.
- busy = 0, done = 0, alu_ctrl = 0x00, alu_a = 0.
- step_count = 0.
- Reset mid-operation aborts with no done pulse. Reset overrides start in the same cycle.

**Latency.** With start accepted at edge N:
- shamt = 0: DONE is the cycle after edge N; done and result are valid there, and the block returns to IDLE at edge N+1.
- shamt > 0 with k steps: SHIFT occupies cycles N+1..N+k and DONE is cycle N+k+1. Latency is k+1 cycles (maximum 8).

**Throughput.** The earliest next accept is the cycle after DONE, i.e. one IDLE cycle between operations.

**Outputs and inputs.**
- busy and done are registered state decodes.
- alu_ctrl and alu_a are stable throughout each SHIFT cycle.
- alu_result must settle within the same cycle (combinational ALU).

## Configuration
- SHIFTSEQ_STATS_EN defined:
  - step_count is a 32-bit counter that increments by 1 for every SHIFT cycle.
  - It saturates at 0xFFFFFFFF and is cleared only by reset.
- SHIFTSEQ_STATS_EN undefined:
  - The step_count port and the counter are absent.
  - All other behaviour is identical.

## Test plan
The bench connects a behavioural ALU model to alu_a, alu_ctrl and alu_result.
- SLL, operand 0x00000001, shamt 13: alu_ctrl sequence is 0x0C, 0x0B, 0x0B, 0x0A. done is high in cycle N+5 with result 0x00002000.
- SRA, operand 0x80000000, shamt 31: seven steps (0x12 ×3, 0x11 ×3, 0x10). done in cycle N+8 with result 0xFFFFFFFF.
- SRL, operand 0xF0000000, shamt 0: done in cycle N+1 with result 0xF0000000. alu_ctrl stays 0x00 throughout.
- start pulsed while busy, and start with op = 3 in IDLE: both ignored, and the in-flight result is unaffected.
- rst_n low during step 2 of an SLL by 20: no done pulse, and all outputs are at reset values on the next cycle. A fresh SLL of 0x1 by 1 then gives 0x00000002 in cycle N+2.
- With SHIFTSEQ_STATS_EN: after shifts by 13, 31 and 0, step_count = 11.
